// File: rtl/sensor_pkg.sv
// Shared sensor definitions: default geometry, ADC code type and full-scale constant.
package sensor_pkg;

    localparam int unsigned DEF_PIXEL_COUNT = 4;
    localparam int unsigned DEF_ADC_BITS    = 8;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;

    typedef logic [DEF_ADC_BITS-1:0] code_t;

    localparam code_t CODE_MAX = '1;

endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO for readout beats. The caller only pushes when there is room
// (or a pop happens on the same edge); overflow accounting lives in the parent.
module readout_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so the output port is clean after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_readout.sv
// Single-slope ADC back end: ramp generation, per-pixel capture on comparator trip,
// full-scale finalize for untripped pixels, and indexed readout into an output FIFO.
// Define PIXEL_READOUT_CDS_EN to build reset-level (ref) storage and the clamped
// sig - ref subtractor; without it `corr` is ignored.
module pixel_readout
    import sensor_pkg::*;
#(
    parameter int unsigned pixel_count = DEF_PIXEL_COUNT,
    parameter int unsigned ADC_BITS    = DEF_ADC_BITS,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           convert,
    input  logic                           corr,
    input  logic                           read,
    input  logic [$clog2(pixel_count)-1:0] pixel_select,
    input  logic [pixel_count-1:0]         cmp,
    output logic [ADC_BITS-1:0]            ramp_code,
    output logic [ADC_BITS-1:0]            out_data,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overflow
);

    localparam int unsigned SEL_W = $clog2(pixel_count);
    localparam logic [ADC_BITS-1:0] CodeMax = '1;
    localparam logic [SEL_W:0]      PixCnt  = (SEL_W+1)'(pixel_count);
    localparam logic [SEL_W-1:0]    LastSel = SEL_W'(pixel_count - 1);

    logic [ADC_BITS-1:0]    ramp_q;
    logic                   conv_q;
    logic [pixel_count-1:0] done_q;
    logic [pixel_count-1:0] cap_en;
    logic [ADC_BITS-1:0]    cap_code;
    logic                   to_ref;
    logic [ADC_BITS-1:0]    sig_q [pixel_count];
    logic [ADC_BITS-1:0]    res   [pixel_count];
    logic                   rd_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   overflow_q;
    logic                   in_range;
    logic [ADC_BITS:0]      push_data;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push_ok;
    logic [ADC_BITS:0]      head;

    assign ramp_code = convert ? ramp_q : '0;

    // Ramp counter: restarts at 0 whenever convert is low, saturates at full scale.
    always_ff @(posedge clk) begin
        if (reset || !convert) begin
            ramp_q <= '0;
        end else if (ramp_q != CodeMax) begin
            ramp_q <= ramp_q + 1'b1;
        end
    end

    // Window tracking: conv_q marks the finalize cycle right after convert falls;
    // done flags latch the first trip and ignore later comparator activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_q <= 1'b0;
            done_q <= '0;
        end else begin
            conv_q <= convert;
            done_q <= convert ? (done_q | cmp) : '0;
        end
    end

    // Capture enables: first trip during the window, or finalize for untripped pixels.
    always_comb begin
        cap_code = convert ? ramp_q : CodeMax;
        cap_en   = '0;
        for (int i = 0; i < pixel_count; i++) begin
            cap_en[i] = convert ? (cmp[i] && !done_q[i]) : (conv_q && !done_q[i]);
        end
    end

`ifdef PIXEL_READOUT_CDS_EN
    logic                corr_q;
    logic [ADC_BITS-1:0] ref_q [pixel_count];

    // Finalize must hit the register the window targeted, so remember its corr.
    assign to_ref = convert ? corr : corr_q;

    // Window target memory for the finalize cycle.
    always_ff @(posedge clk) begin
        if (reset)        corr_q <= 1'b0;
        else if (convert) corr_q <= corr;
    end

    // Reset-level sample store.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pixel_count; i++) begin
            if (reset)                   ref_q[i] <= '0;
            else if (cap_en[i] && to_ref) ref_q[i] <= cap_code;
        end
    end

    // Clamped difference: a reference above the signal reads as zero.
    always_comb begin
        for (int i = 0; i < pixel_count; i++) begin
            res[i] = (sig_q[i] > ref_q[i]) ? (sig_q[i] - ref_q[i]) : '0;
        end
    end
`else
    logic unused_corr;
    assign unused_corr = corr;
    assign to_ref      = 1'b0;

    // Result is the raw signal sample.
    always_comb begin
        for (int i = 0; i < pixel_count; i++) begin
            res[i] = sig_q[i];
        end
    end
`endif

    // Signal sample store.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pixel_count; i++) begin
            if (reset)                     sig_q[i] <= '0;
            else if (cap_en[i] && !to_ref) sig_q[i] <= cap_code;
        end
    end

    // Readout request pipeline: register the index, push on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= 1'b0;
            sel_q <= '0;
        end else begin
            rd_q <= read;
            if (read) sel_q <= pixel_select;
        end
    end

    // Push payload is {last, code}; out-of-range indices push code 0.
    always_comb begin
        in_range  = ({1'b0, sel_q} < PixCnt);
        push_data = '0;
        if (in_range) push_data[ADC_BITS-1:0] = res[sel_q];
        push_data[ADC_BITS] = (sel_q == LastSel);
    end

    assign pop     = !fifo_empty && out_ready;
    assign push_ok = rd_q && (!fifo_full || pop);

    // Sticky overflow: a push that found the FIFO full with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset)                            overflow_q <= 1'b0;
        else if (rd_q && fifo_full && !pop)   overflow_q <= 1'b1;
    end

    readout_fifo #(
        .WIDTH (ADC_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[ADC_BITS-1:0];
    assign out_last  = head[ADC_BITS];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: ramp/capture, streaming readout, back-pressure
// and overflow, reset abort, and the corr path (CDS or ignored, per build).
module tb_pixel_readout;
    import sensor_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       convert;
    logic       corr;
    logic       read;
    logic [1:0] pixel_select;
    logic [3:0] cmp;
    logic [7:0] ramp_code;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] got_q [$];

    always #5 clk = ~clk;

    pixel_readout #(
        .pixel_count (4),
        .ADC_BITS    (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .convert      (convert),
        .corr         (corr),
        .read         (read),
        .pixel_select (pixel_select),
        .cmp          (cmp),
        .ramp_code    (ramp_code),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow)
    );

    // Record every accepted beat as {last, code}; inputs are settled at negedge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_last, out_data});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Conversion window of n cycles; pixel i trips at ramp index t_i (>= n means never).
    // With glitch2 set, pixel 2 is high only on its trip cycle.
    task automatic do_conv(input int n, input int t0, input int t1, input int t2, input int t3,
                           input bit glitch2, input bit c);
        for (int k = 0; k < n; k++) begin
            convert = 1'b1;
            corr    = c;
            cmp[0]  = (k >= t0);
            cmp[1]  = (k >= t1);
            cmp[2]  = glitch2 ? (k == t2) : (k >= t2);
            cmp[3]  = (k >= t3);
            #1;
            if (k == 0 || k == 255 || k == n - 1)
                check($sformatf("ramp_k%0d", k), ramp_code, (k > 255) ? 255 : k);
            tick();
        end
        convert = 1'b0;
        corr    = 1'b0;
        cmp     = '0;
        #1;
        check("ramp_idle", ramp_code, 0);
    endtask

    task automatic read_stream(input int n, input int start, input bit lat);
        for (int i = 0; i < n; i++) begin
            read         = 1'b1;
            pixel_select = 2'((start + i) % 4);
            #1;
            if (lat && i == 1) check("valid_lat1", out_valid, 0);
            if (lat && i == 2) check("valid_lat2", out_valid, 1);
            tick();
        end
        read = 1'b0;
    endtask

    task automatic check_beats(input int n, input int start,
                               input int c0, input int c1, input int c2, input int c3);
        int codes [4];
        int s;
        codes = '{c0, c1, c2, c3};
        check("beat_count", got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                s = (start + i) % 4;
                check($sformatf("beat%0d_code", i), got_q[i][7:0], codes[s]);
                check($sformatf("beat%0d_last", i), got_q[i][8], (s == 3) ? 1 : 0);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        convert      = 1'b0;
        corr         = 1'b0;
        read         = 1'b0;
        pixel_select = '0;
        cmp          = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        check("rst_ramp", ramp_code, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // Ramp/capture with a glitching pixel and an untripped pixel, then
        // back-to-back readout starting in the finalize cycle.
        out_ready = 1'b1;
        got_q.delete();
        do_conv(255, 10, 200, 5, 256, 1'b1, 1'b0);
        read_stream(4, 0, 1'b1);
        repeat (6) tick();
        check_beats(4, 0, 10, 200, 5, 255);
        check("stream_ovf", overflow, 0);

        // Back-pressure: six requests into a four-deep FIFO.
        got_q.delete();
        out_ready = 1'b0;
        read_stream(6, 0, 1'b0);
        repeat (3) tick();
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 10);
        check("bp_last", out_last, 0);
        check("bp_ovf", overflow, 1);
        repeat (3) tick();
        check("bp_data_hold", out_data, 10);
        out_ready = 1'b1;
        repeat (8) tick();
        check_beats(4, 0, 10, 200, 5, 255);
        check("bp_drained", out_valid, 0);
        check("bp_ovf_sticky", overflow, 1);

        // Reset mid-conversion with a beat already queued.
        got_q.delete();
        out_ready = 1'b0;
        read_stream(1, 1, 1'b0);
        tick();
        tick();
        check("pre_rst_valid", out_valid, 1);
        for (int k = 0; k <= 50; k++) begin
            convert = 1'b1;
            cmp     = {3'b000, (k >= 30)};
            if (k == 50) reset = 1'b1;
            #1;
            if (k == 50) check("pre_rst_ramp", ramp_code, 50);
            tick();
        end
        check("mid_rst_ramp", ramp_code, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ovf", overflow, 0);
        tick();
        reset     = 1'b0;
        convert   = 1'b0;
        cmp       = '0;
        out_ready = 1'b1;
        read_stream(4, 0, 1'b0);
        repeat (6) tick();
        check_beats(4, 0, 0, 0, 0, 0);

        got_q.delete();
`ifdef PIXEL_READOUT_CDS_EN
        // Reference at 20 for pixels 0/1, signal 120 and 15: second result clamps to 0.
        do_conv(130, 20, 20, 256, 256, 1'b0, 1'b1);
        tick();
        do_conv(130, 120, 15, 256, 256, 1'b0, 1'b0);
        read_stream(4, 0, 1'b0);
        repeat (6) tick();
        check_beats(4, 0, 100, 0, 0, 0);
`else
        // corr must be ignored; long window also exercises ramp saturation.
        do_conv(300, 20, 280, 300, 300, 1'b0, 1'b1);
        read_stream(4, 0, 1'b0);
        repeat (6) tick();
        check_beats(4, 0, 20, 255, 255, 255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Digital back end of the sensor's single-slope ADC, directly downstream of the exposure/readout controller. While the controller holds `convert`, the block drives a shared ramp code to the column DAC and captures per-pixel codes when each comparator trips. While the controller holds `read`, it streams the captured codes, indexed by the controller's `pixel_select`, into a small output FIFO with a valid/ready handshake. With correlated double sampling (CDS) compiled in, it also stores a reset-level sample per pixel and outputs the difference.

## Interface
Parameters:
- `pixel_count`, 4: number of pixels; must match the controller.
- `ADC_BITS`, 8: ramp and sample code width.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `convert`  in  1  conversion window from the controller.
- `corr`  in  1  the current conversion is the reset-level (CDS reference) sample.
- `read`  in  1  readout window from the controller.
- `pixel_select`  in  $clog2(pixel_count)  pixel index, valid while `read`=1.
- `cmp`  in  pixel_count  comparator outputs; bit i is 1 once the ramp has crossed pixel i.
- `ramp_code`  out  ADC_BITS  code to the ramp DAC.
- `out_data`  out  ADC_BITS  pixel code at the FIFO head.
- `out_last`  out  1  head entry is pixel `pixel_count-1`.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  sink accepts the head entry.
- `overflow`  out  1  sticky flag: a push was dropped because the FIFO was full.

## Operation
- Ramp:
  - `ramp_code` is forced to 0 on any cycle where `convert`=0.
  - While `convert`=1, `ramp_code` increments by 1 per cycle and saturates at 2^ADC_BITS−1, with no wrap.
  - The first cycle with `convert`=1 therefore presents code 0, and the k-th cycle presents min(k, max).
- Capture:
  - Each pixel has a `done` flag, cleared on every cycle where `convert`=0.
  - On a `convert`=1 cycle where `cmp[i]`=1 and `done[i]`=0, the current `ramp_code` is written to `sig[i]` (or to `ref[i]` if `corr`=1 and CDS is enabled), and `done[i]` is set.
  - Later comparator activity in the same window is ignored, including glitches back to 0.
- Finalize: on the first cycle after `convert` falls, every pixel still not `done` gets the full-scale value (2^ADC_BITS−1) written to its target register.
- Result: `res[i]` = `sig[i]` (CDS disabled), or `sig[i]`−`ref[i]` clamped at 0 (CDS enabled).
- Readout:
  - On each cycle with `read`=1, `pixel_select` is registered.
  - On the following cycle, {`res[sel]`, `sel`==`pixel_count-1`} is pushed into the FIFO.
- Overflow:
  - A push while the FIFO is full is dropped and sets `overflow`.
  - A simultaneous pop and push on a full FIFO succeeds.
  - `overflow` clears only on `reset`.
- Handshake: an entry leaves the FIFO on a cycle where `out_valid`=1 and `out_ready`=1. `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Out-of-range `pixel_select` (≥`pixel_count`) pushes code 0.

## Timing
- Reset values:
  - `ramp_code`, `out_data`, `out_last`, `out_valid`, `overflow`: 0.
  - All `sig`, `ref`, `res` registers and `done` flags: 0.
  - FIFO: empty.
- Capture latency: `cmp[i]` seen high on the cycle with `ramp_code`=k stores k at that clock edge.
- The finalize write completes one cycle after `convert` falls. This is the same edge as the first `pixel_select` registration, so readout that follows conversion back-to-back sees finalized codes.
- Push latency: a pixel index sampled on cycle n enters the FIFO on cycle n+1. `out_valid` rises on cycle n+2 if the FIFO was empty.
- `reset` asserted mid-conversion or mid-read aborts the operation: the FIFO is emptied, all results are zeroed, and nothing in flight is pushed.

## Configuration
- `PIXEL_READOUT_CDS_EN` defined:
  - `corr` routes captures to `ref`.
  - Results are the clamped difference `sig`−`ref`.
- Not defined:
  - `corr` is ignored; every conversion writes `sig`.
  - `ref` registers and the subtractor are not built.

## Structure
- Shared package `sensor_pkg`:
  - default `pixel_count` and `ADC_BITS`;
  - typedef `code_t` (logic [ADC_BITS-1:0]);
  - constant `CODE_MAX`.
- One sub-module: `readout_fifo`, a synchronous FIFO with push/pop/full/empty and an ADC_BITS+1 data width. Overflow detection stays in the parent.

## Test plan
- Ramp and capture: convert high 255 cycles, `cmp[0]` rises at ramp 10, `cmp[1]` at 200, `cmp[2]` glitches high at 5 and low at 6, `cmp[3]` never rises → res = {10, 200, 5, 255}.
- Readout stream: 4 `read` cycles, `pixel_select` 0..3, `out_ready`=1 → four beats {10, 200, 5, 255}, `out_last` only on the fourth, `out_valid` first high two cycles after `read`.
- Back-pressure and overflow with FIFO_DEPTH=4: `out_ready`=0 through 6 read cycles → 4 entries held stable, `overflow`=1. Then `out_ready`=1 → exactly 4 beats in order.
- CDS (macro defined): `corr`=1 conversion with trips at 20, then `corr`=0 conversion with pixel 0 at 120 and pixel 1 at 15 → res0=100, res1=0 (clamped).
- Reset mid-conversion: `reset` pulsed at ramp 50 → `ramp_code`=0 and `out_valid`=0 next cycle. A subsequent read streams zeros for pixels not converted again.
